// File: rtl/mult4_shift_add_pkg.sv
// Shared constants for the shift-and-add multiplier: operand sizes, iteration count, FSM states.
package mult4_shift_add_pkg;

  localparam int OP_W       = 4;
  localparam int PROD_W     = 2 * OP_W;
  localparam int ITER_COUNT = 4;

  // 2'd3 is unused; the FSM treats it as idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult4_shift_add_if.sv
// Request/response bundle for mult4_shift_add: start with operands in, status and product out.
interface mult4_shift_add_if;
  import mult4_shift_add_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              ready;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (output start, a, b, input ready, busy, done, product);
  modport slave  (input start, a, b, output ready, busy, done, product);

endinterface

// File: rtl/fulladder4.sv
// 4-bit ripple-carry adder: {co,sum} = a + b + cin.
// Purely combinational, no storage and no flow control.
module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/mult4_shift_add.sv
// 4x4 unsigned shift-and-add multiplier; product 5 cycles after the start edge (done pulse).
// start accepted only while ready; requests during RUN/DONE are dropped, not queued.
module mult4_shift_add
  import mult4_shift_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  mult4_shift_add_if.slave bus
);

  if (WIDTH != OP_W) begin : g_width_chk
    $error("mult4_shift_add: WIDTH must be 4 to match fulladder4");
  end

  localparam logic [1:0] LAST_CNT = 2'(ITER_COUNT - 1);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   mcand_q, mcand_d;
  logic [PROD_W-1:0] p_q, p_d, p_iter;
  logic [PROD_W-1:0] product_q, product_d;
  logic [1:0]        count_q, count_d;
  logic [OP_W-1:0]   sum;
  logic              co;

  fulladder4 u_add (
    .a   (p_q[7:4]),
    .b   (mcand_q),
    .cin (1'b0),
    .sum (sum),
    .co  (co)
  );

  // Carry-out lands in bit 7 so the 8-bit result stays exact.
  assign p_iter = p_q[0] ? {co, sum, p_q[3:1]} : {1'b0, p_q[7:4], p_q[3:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    product_d = product_q;
    count_d   = count_q;
    case (state_q)
      ST_RUN: begin
        p_d     = p_iter;
        count_d = count_q + 2'd1;
        if (count_q == LAST_CNT) begin
          state_d   = ST_DONE;
          product_d = p_iter;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        if (bus.start) begin
          state_d = ST_RUN;
          mcand_d = bus.a;
          p_d     = {4'b0, bus.b};
          count_d = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  assign bus.ready   = (state_q != ST_RUN) && (state_q != ST_DONE);
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult4_shift_add.sv
// Scoreboard bench for mult4_shift_add: accepted requests queue a*b, done pulses pop and compare.
module tb_mult4_shift_add;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mult4_shift_add_if bus ();

  mult4_shift_add #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prod;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_chk       = 0;
  int   n_pass      = 0;
  int   cyc         = 0;
  int   done_seen   = 0;
  int   expected_ops = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: requests seen accepted are scored a*b due 5 negedges later.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].due < cyc) begin
        check("done_missing", 0, 1);
        void'(q.pop_front());
      end
      if (bus.done === 1'b1) begin
        done_seen++;
        if (q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check("product", int'(bus.product), e.prod);
          check("done_latency", cyc, e.due);
        end
      end
      if (bus.ready === 1'b1 && bus.start === 1'b1) begin
        e.prod = int'(bus.a) * int'(bus.b);
        e.due  = cyc + 5;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic finish_op();
    bit ok;
    wait_done(ok);
    if (ok) begin
      check("ready_in_done", int'(bus.ready), 0);
      tick();
      check("ready_after_done", int'(bus.ready), 1);
      check("done_one_cycle", int'(bus.done), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ta[6];
    logic [3:0] tb_[6];
    bit ok;
    int prev;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check("rst_ready",   int'(bus.ready),   1);
    check("rst_busy",    int'(bus.busy),    0);
    check("rst_done",    int'(bus.done),    0);
    check("rst_product", int'(bus.product), 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", int'(bus.ready), 1);

    // Zero operands, then corner and mixed patterns.
    start_op(4'd0, 4'd0);
    check("busy_in_run", int'(bus.busy), 1);
    finish_op();
    expected_ops++;

    ta  = '{4'd15, 4'd12, 4'd5,  4'd1, 4'd10, 4'd7};
    tb_ = '{4'd15, 4'd3,  4'd15, 4'd8, 4'd15, 4'd0};
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb_[i]);
      finish_op();
      expected_ops++;
    end

    // Requests during RUN and DONE must be ignored.
    start_op(4'd3, 4'd4);
    tick();
    bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(ok);
    expected_ops++;
    bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ignore_done_ready", int'(bus.ready), 1);
    check("ignore_done_busy",  int'(bus.busy),  0);
    tick();
    check("ignore_stays_idle", int'(bus.busy), 0);
    check("ignore_product", int'(bus.product), 12);

    // Reset mid-RUN discards the operation.
    start_op(4'd15, 4'd15);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_product", int'(bus.product), 0);
    check("midrst_ready",   int'(bus.ready),   1);
    check("midrst_busy",    int'(bus.busy),    0);
    check("midrst_done",    int'(bus.done),    0);
    bus.a = 4'd2; bus.b = 4'd7; bus.start = 1'b1;
    tick();
    tick();
    check("rst_holds_idle", int'(bus.busy), 0);
    rst_n = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_after_release", int'(bus.busy), 1);
    finish_op();
    expected_ops++;

    // Continuous start: back-to-back random operations 6 cycles apart.
    bus.a = 4'($urandom); bus.b = 4'($urandom); bus.start = 1'b1;
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      wait_done(ok);
      if (!ok) break;
      if (i > 0) check("spacing", cyc - prev, 6);
      prev = cyc;
      expected_ops++;
      if (i == 199) bus.start = 1'b0;
      else begin
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
      end
    end
    bus.start = 1'b0;
    tick();
    tick();
    check("final_idle", int'(bus.ready), 1);
    tick();

    check("done_count", done_seen, expected_ops);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
